// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN for an extra parity bit (8E1/8O1).
// Latency: TXD write at edge N -> START at N+1 -> tx falls after N+2; each bit BAUD_DIV cycles.
// Backpressure: one-entry hold buffer; a TXD write while it is full is dropped and flagged in TX_OVR.
module uart_tx_mmio #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter logic [31:0] TXD_ADDR = 32'h4000_0018,
    parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic [7:0]  shifter, hold, last_byte;
    logic        hold_valid, tx_ie, tx_done, tx_ovr;
    logic        load, shift, done_set, tx_nxt, baud_wrap;
    logic        txd_wr, con_wr, con_rd;
    logic        unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic        par_odd, par_bit;
`endif

    assign txd_wr       = MemWrite && (addr == TXD_ADDR);
    assign con_wr       = MemWrite && (addr == CON_ADDR);
    assign con_rd       = MemRead && (addr == CON_ADDR);
    assign baud_wrap    = (baud_cnt == BAUD_LAST);
    assign irq          = tx_ie & tx_done;
    assign unused_wdata = ^{wdata[31:8], wdata[1]};

    always_comb begin
        rdata = '0;
        if (MemRead && (addr == TXD_ADDR)) begin
            rdata = {24'b0, last_byte};
        end else if (con_rd) begin
            rdata[0] = tx_ie;
`ifdef UART_TX_PARITY_EN
            rdata[1] = par_odd;
`endif
            rdata[2] = tx_done;
            rdata[3] = tx_ovr;
            rdata[4] = (state != IDLE) | hold_valid;
            rdata[5] = hold_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_wrap ? '0 : baud_cnt + 16'd1;
        bit_nxt   = bit_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        done_set  = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (hold_valid) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_wrap) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                tx_nxt = shifter[0];
                if (baud_wrap) begin
                    shift   = 1'b1;
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_nxt = par_bit;
                if (baud_wrap) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    done_set = 1'b1;
                    // refilled hold chains straight into the next start bit
                    if (hold_valid) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            tx       <= tx_nxt;
            if (load) shifter <= hold;
            else if (shift) shifter <= {1'b0, shifter[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            last_byte  <= '0;
            tx_ie      <= 1'b0;
            tx_done    <= 1'b0;
            tx_ovr     <= 1'b0;
        end else begin
            if (txd_wr) last_byte <= wdata[7:0];
            // a write landing on the transfer edge reuses the slot being vacated
            if (txd_wr && (!hold_valid || load)) begin
                hold       <= wdata[7:0];
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
            if (con_wr) tx_ie <= wdata[0];
            if (done_set) tx_done <= 1'b1;
            else if (con_rd) tx_done <= 1'b0;
            if (txd_wr && hold_valid && !load) tx_ovr <= 1'b1;
            else if (con_rd) tx_ovr <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_odd <= 1'b0;
            par_bit <= 1'b0;
        end else begin
            if (con_wr) par_odd <= wdata[1];
            if (load) par_bit <= (^hold) ^ par_odd;
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio at BAUD_DIV=4: serial frames and bus reads are checked by a negedge monitor.
module tb_uart_tx_mmio;
    localparam int BD = 4;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] CON = 32'h4000_0020;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] addr, wdata, rdata;
    logic        tx, irq;

    always #5 clk = ~clk;

    uart_tx_mmio #(.BAUD_DIV(BD), .TXD_ADDR(TXD), .CON_ADDR(CON)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          frames = 0;
    int          fexp = 0;
    int          k;
    time         t_last, t_wr;
    logic [8:0]  exp_q[$];
    logic [31:0] rd_q[$];
    string       rd_nm[$];
    time         start_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(posedge clk);
        t_last = $time;
        #1;
        MemWrite = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_q.push_back(exp);
        rd_nm.push_back(nm);
        addr = a; MemRead = 1'b1;
        @(posedge clk);
        #1;
        MemRead = 1'b0; addr = '0;
    endtask

    task automatic send(input logic [7:0] b, input logic par);
        exp_q.push_back({par, b});
        fexp++;
        bus_write(TXD, {24'b0, b});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int c = 0;
        while (frames < target && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("frames_seen", frames, target);
    endtask

    // monitor: bus reads compared while MemRead is high; serial frames decoded mid-bit
    int          mon_idx, mon_b;
    bit          mon_busy = 1'b0;
    logic [7:0]  mon_byte;
    logic [8:0]  mon_x;
    logic [31:0] mon_e;
    string       mon_s;
`ifdef UART_TX_PARITY_EN
    logic        mon_par;
`endif

    always @(negedge clk) begin
        if (MemRead) begin
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h, no read expected", rdata);
            end else begin
                mon_e = rd_q.pop_front();
                mon_s = rd_nm.pop_front();
                check(mon_s, rdata, mon_e);
            end
        end
        if (!rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx == 1'b0) begin
                mon_busy = 1'b1;
                mon_idx = 0;
                start_q.push_back($time);
            end
        end else begin
            mon_idx++;
        end
        if (mon_busy && rst && (mon_idx % BD == BD / 2)) begin
            mon_b = mon_idx / BD;
            if (mon_b == 0) begin
                check("start_bit", 32'(tx), 32'd0);
            end else if (mon_b <= 8) begin
                mon_byte[mon_b-1] = tx;
`ifdef UART_TX_PARITY_EN
            end else if (mon_b == 9) begin
                mon_par = tx;
`endif
            end else begin
                check("stop_bit", 32'(tx), 32'd1);
                frames++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_frame: got byte 0x%0h, none required", mon_byte);
                end else begin
                    mon_x = exp_q.pop_front();
                    check("frame_byte", 32'(mon_byte), 32'(mon_x[7:0]));
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", 32'(mon_par), 32'(mon_x[8]));
`endif
                end
            end
        end
        if (mon_busy && mon_idx == NB * BD - 1) mon_busy = 1'b0;
    end

    initial begin
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
        idle(3);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        idle(1);
        bus_read(CON, 32'h00, "reset_con");
        bus_read(TXD, 32'h00, "reset_txd");

        // non-matching write must not start a frame
        bus_write(32'h4000_001C, 32'hFF);
        idle(60);

        // reset during the start bit aborts the frame
        bus_write(TXD, 32'h33);
        repeat (3) @(posedge clk);
        #2;
        check("midframe_tx_low", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        idle(2);
        rst = 1'b1;
        idle(1);
        bus_read(CON, 32'h00, "after_reset_con");
        bus_read(TXD, 32'h00, "after_reset_txd");
        idle(60);

        // single frame 0xA5
        send(8'hA5, 1'b0);
        t_wr = t_last;
        bus_read(CON, 32'h30, "con_hold_full");
        bus_read(CON, 32'h10, "con_busy");
        wait_frames(fexp);
        check("start_latency", 32'(start_q[start_q.size()-1] - t_wr), 32'd25);
        idle(3);
        bus_read(CON, 32'h04, "con_done");
        bus_read(CON, 32'h00, "con_cleared");
        bus_read(TXD, 32'hA5, "txd_last_byte");
        bus_read(32'h4000_0019, 32'h0, "miss_offset");
        bus_read(32'hC000_0018, 32'h0, "miss_high_bit");

        // interrupt: only TX_IE is writable
        bus_write(CON, 32'h3D);
        bus_read(CON, 32'h01, "con_ie_only");
        send(8'h00, 1'b0);
        t_wr = t_last;
        check("irq_low_busy", 32'(irq), 32'd0);
        k = 0;
        while (!irq && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("irq_rise_time", 32'($time - t_wr), 32'd415);
        @(posedge clk);
        #1;
        idle(4);
        check("irq_held", 32'(irq), 32'd1);
        bus_read(CON, 32'h05, "con_ie_done");
        check("irq_cleared", 32'(irq), 32'd0);
        bus_write(CON, 32'h0);
        wait_frames(fexp);

        // back-to-back, third write overflows
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        fexp--;
        void'(exp_q.pop_back());
        exp_q.push_back({1'b0, 8'hAA});
        fexp++;
        bus_write(TXD, 32'h0F);
        bus_read(CON, 32'h38, "con_ovr_full");
        bus_read(TXD, 32'h0F, "txd_dropped_last");
        wait_frames(fexp);
        check("b2b_spacing", 32'(start_q[start_q.size()-1] - start_q[start_q.size()-2]), 32'(NB * BD * 10));
        idle(3);
        bus_read(CON, 32'h04, "con_after_b2b");
        idle(60);

        // CON read on the edge TX_DONE sets
        send(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        bus_read(CON, 32'h10, "race_old_value");
        bus_read(CON, 32'h04, "race_set_wins");
        wait_frames(fexp);

`ifdef UART_TX_PARITY_EN
        bus_write(CON, 32'h0);
        send(8'h07, 1'b1);
        wait_frames(fexp);
        bus_write(CON, 32'h2);
        bus_read(CON, 32'h06, "con_par_odd");
        send(8'h07, 1'b0);
        idle(5);
        bus_write(CON, 32'h0);
        wait_frames(fexp);
        idle(3);
        bus_read(CON, 32'h04, "con_after_parity");
`endif

        idle(20);
        check("leftover_frames", 32'(exp_q.size()), 32'd0);
        check("leftover_reads", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
